// File: rtl/serial_magnitude_comparator_if.sv
`timescale 1ns/1ps
// Handshake/operand bundle for serial_magnitude_comparator.
// master: requester (drives start/a/b/is_signed, observes status and result flags).
// slave : comparator (samples the request, drives busy/done and the result flags).
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, a_gt_b, a_eq_b, a_lt_b
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, a_gt_b, a_eq_b, a_lt_b
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
`timescale 1ns/1ps
// Purpose : bit-serial MSB-first magnitude compare of two WIDTH-bit operands, unsigned or two's-complement.
// Latency : capture edge + 1..WIDTH scan edges (first differing bit) with EARLY_EXIT=1, always WIDTH with EARLY_EXIT=0.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped, busy tells the requester when to retry.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset (abandons any scan, no done issued)
//   cmp_if - slave side of serial_magnitude_comparator_if:
//            start/a/b/is_signed in; busy, done (1-cycle pulse), a_gt_b/a_eq_b/a_lt_b (held) out
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_magnitude_comparator_if.slave cmp_if
);

  localparam int                 IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]   MSB_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [IDX_W-1:0] idx_q;
  logic             decided_q;
  logic             pend_gt_q;   // result latched at the first differing bit when scanning on
  logic             pend_lt_q;
  logic             busy_q;
  logic             done_q;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;

  // Per-bit step, evaluated on the bit currently addressed by idx_q.
  logic bit_a;
  logic bit_b;
  logic bit_diff;
  logic sign_pos;
  logic a_wins;
  logic decided_d;
  logic res_gt_d;
  logic res_lt_d;
  logic finish_d;

  always_comb begin
    bit_a     = a_q[idx_q];
    bit_b     = b_q[idx_q];
    bit_diff  = bit_a ^ bit_b;
    // At the sign position of a signed compare a 1 marks the negative (smaller)
    // operand, so the sense of the decision flips there.
    sign_pos  = sgn_q && (idx_q == MSB_IDX);
    a_wins    = bit_a ^ sign_pos;
    decided_d = decided_q | bit_diff;
    // Once decided, later bits are ignored: the pending result is sticky.
    res_gt_d  = decided_q ? pend_gt_q : (bit_diff & a_wins);
    res_lt_d  = decided_q ? pend_lt_q : (bit_diff & ~a_wins);
    finish_d  = (idx_q == '0) || (EARLY_EXIT && bit_diff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      pend_gt_q <= 1'b0;
      pend_lt_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmp_if.start) begin
            a_q       <= cmp_if.a;
            b_q       <= cmp_if.b;
            sgn_q     <= cmp_if.is_signed;
            idx_q     <= MSB_IDX;
            decided_q <= 1'b0;
            pend_gt_q <= 1'b0;
            pend_lt_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          if (finish_d) begin
            // Result flags only move here, so they hold through the next scan.
            gt_q    <= res_gt_d;
            lt_q    <= res_lt_d;
            eq_q    <= ~(res_gt_d | res_lt_d);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q     <= idx_q - 1'b1;
            decided_q <= decided_d;
            pend_gt_q <= res_gt_d;
            pend_lt_q <= res_lt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmp_if.busy   = busy_q;
  assign cmp_if.done   = done_q;
  assign cmp_if.a_gt_b = gt_q;
  assign cmp_if.a_eq_b = eq_q;
  assign cmp_if.a_lt_b = lt_q;

  // Structural invariants of the published result.
  a_onehot_on_done : assert property (@(posedge clk) disable iff (!rst_n)
                                      done_q |-> $onehot({gt_q, eq_q, lt_q}));
  a_done_not_busy  : assert property (@(posedge clk) disable iff (!rst_n)
                                      !(done_q && busy_q));

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Parametrised, bit-serial successor to the team's 2-bit gate-level magnitude comparator.
- Captures two WIDTH-bit operands on a start request and scans them MSB-first, one bit per clock.
- Produces registered, mutually exclusive gt/eq/lt flags with a one-cycle done pulse.
- Supports unsigned and two's-complement operands, and either early-exit or constant-latency operation. Used wherever wide comparisons are needed without a wide combinational compare path.

Parameters:
- WIDTH, 8, operand width in bits; legal range >= 1.
- EARLY_EXIT, 1, 1 = finish at the first differing bit; 0 = always scan all WIDTH bits (constant latency).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- is_signed  input  1  1 = two's-complement compare; captured with the operands.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when a result is published.
- a_gt_b  output  1  A > B (registered, held).
- a_eq_b  output  1  A == B (registered, held).
- a_lt_b  output  1  A < B (registered, held).

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous, active-low.
- Reset values: state IDLE; busy, done, a_gt_b, a_eq_b, a_lt_b all 0; bit index and decided flag cleared. Reset takes priority over every other event, including mid-scan: the scan is abandoned, no done is issued, and start is ignored while rst_n = 0.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - start = 1 at edge E0 captures a, b and is_signed, sets idx = WIDTH-1, and moves to SCAN with busy = 1 from E0.
  - start = 0 leaves the FSM in IDLE.
- SCAN, per edge Ek (k = 1, 2, ...), examines bit idx of the captured operands:
  - Bits differ, idx = WIDTH-1, is_signed = 1: the operand with bit = 1 is negative and therefore smaller (a bit 1 -> lt, else gt).
  - Bits differ otherwise: the operand with bit = 1 is larger (a bit 1 -> gt, else lt).
  - Bits equal: continue to the next bit.
  - Only the first differing bit is decisive; later bits never alter a decided result (sticky decided flag).
- Completion:
  - EARLY_EXIT = 1: at the edge that examines the first differing bit (n = WIDTH - idx), or at bit 0 if no bit differs (n = WIDTH, result eq).
  - EARLY_EXIT = 0: always at E_WIDTH.
  - At the completion edge: result flags load with exactly one flag = 1, done = 1 for one cycle, busy = 0, FSM returns to IDLE, and idx stops decrementing.
- Result hold: flags stay stable until the next completion and do not change during a subsequent scan. Before the first completion after reset, all three flags are 0.
- Back-to-back: start may be asserted during the done cycle (FSM already in IDLE) and is accepted at the next edge. Maximum throughput is one comparison per WIDTH+1 cycles.
- Start while busy is ignored. Input changes on a, b or is_signed after capture have no effect on the running compare.
- WIDTH = 1: the single bit is the sign bit when is_signed = 1 (1 = -1 < 0). Latency is always 1 edge.
- Arithmetic: no subtraction or adder chain. idx needs ceil(log2(WIDTH)) bits, minimum 1.

Test Plan:
- Early exit: WIDTH=8, EARLY_EXIT=1, unsigned, a=0xA5, b=0x25 -> a_gt_b=1 with done one edge after capture (n=1); then a=0x3C, b=0x3C -> a_eq_b=1 at n=8.
- Signed vs unsigned: a=0x80, b=0x7F, is_signed=1 -> a_lt_b=1; same operands with is_signed=0 -> a_gt_b=1. Also a=0xFF, b=0xFE, signed -> a_gt_b=1 (-1 > -2).
- Constant latency: EARLY_EXIT=0, a=0x80, b=0x00 -> a_gt_b=1 with done exactly at E8; busy high during E0..E8 intervals, low on the done cycle.
- Handshake: start pulsed mid-scan with different operands -> ignored, first result unchanged. start held high through the done cycle -> a new compare is accepted at the next edge, and the previous flags are held until its completion.
- Reset mid-operation: rst_n=0 at E3 of an 8-bit scan -> next cycle busy=0, done=0, all flags 0; no done is emitted for the abandoned scan; a fresh start afterwards completes normally.
- Exhaustive: WIDTH=2, both is_signed values, both EARLY_EXIT values, all 16 operand pairs -> flags match a behavioural compare, exactly one flag high per done, and done latency matches the completion rules above.
